// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: two requesting masters on one side and a single
// Wishbone-style RAM port on the other.
// slave modport  : the arbiter's view (takes master requests, drives the RAM).
// master modport : the environment's view (masters plus RAM model).
interface ram_arbiter_if;
  logic        pinM0CycleStrobe;
  logic        pinM1CycleStrobe;
  logic        pinM0WriteEnable;
  logic        pinM1WriteEnable;
  logic [31:0] pinM0Address;
  logic [31:0] pinM1Address;
  logic [31:0] pinM0WriteData;
  logic [31:0] pinM1WriteData;
  logic [31:0] pinM0ReadData;
  logic [31:0] pinM1ReadData;
  logic        pinM0Ack;
  logic        pinM1Ack;
  logic        pinWbCycleStrobe;
  logic        pinWbWriteEnable;
  logic [31:0] pinWbAddress;
  logic [31:0] pinWbWriteData;
  logic [31:0] pinWbReadData;
  logic        pinWbAck;

  modport slave (
    input  pinM0CycleStrobe, pinM1CycleStrobe,
    input  pinM0WriteEnable, pinM1WriteEnable,
    input  pinM0Address, pinM1Address,
    input  pinM0WriteData, pinM1WriteData,
    output pinM0ReadData, pinM1ReadData,
    output pinM0Ack, pinM1Ack,
    output pinWbCycleStrobe, pinWbWriteEnable,
    output pinWbAddress, pinWbWriteData,
    input  pinWbReadData, pinWbAck
  );

  modport master (
    output pinM0CycleStrobe, pinM1CycleStrobe,
    output pinM0WriteEnable, pinM1WriteEnable,
    output pinM0Address, pinM1Address,
    output pinM0WriteData, pinM1WriteData,
    input  pinM0ReadData, pinM1ReadData,
    input  pinM0Ack, pinM1Ack,
    input  pinWbCycleStrobe, pinWbWriteEnable,
    input  pinWbAddress, pinWbWriteData,
    output pinWbReadData, pinWbAck
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single RAM port.
// A grant is registered (IDLE arbitration cycle first), then the owner's bus
// fields pass straight through to the RAM until ack or strobe drop.
// Ties go to the master that did not own the previous grant.
// Optional feature: define RAM_ARBITER_TIMEOUT_EN to add a grant watchdog that
// terminates a stuck RAM cycle with a forced ack and a sticky pinTimeoutFlag.
module ram_arbiter #(
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic          pinClock,
  input  logic          pinReset,
  ram_arbiter_if.slave  bus,
  output logic          pinTimeoutFlag
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arbState;

  arbState                  state;
  arbState                  nextState;
  logic                     lastOwner;
  logic                     nextLastOwner;
  logic                     ownerStrobe;
  logic                     timeoutExpire;
  logic [TIMEOUT_WIDTH-1:0] timeoutCount;

  assign ownerStrobe = (state == GRANT0) ? bus.pinM0CycleStrobe :
                       (state == GRANT1) ? bus.pinM1CycleStrobe : 1'b0;

  // Expiry happens in the grant cycle whose count is all ones (the entry
  // cycle has count 0); a real ack or a withdrawn request takes precedence.
  assign timeoutExpire = ownerStrobe && !bus.pinWbAck && (&timeoutCount);

  assign bus.pinM0ReadData = bus.pinWbReadData;
  assign bus.pinM1ReadData = bus.pinWbReadData;

`ifdef RAM_ARBITER_TIMEOUT_EN
  // Watchdog: held at zero while idle, counts every grant cycle without ack
  always_ff @(posedge pinClock or posedge pinReset) begin
    if (pinReset) begin
      timeoutCount <= '0;
    end else if (state == IDLE) begin
      timeoutCount <= '0;
    end else if (!bus.pinWbAck) begin
      timeoutCount <= timeoutCount + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge pinClock or posedge pinReset) begin
    if (pinReset) begin
      pinTimeoutFlag <= 1'b0;
    end else if (timeoutExpire) begin
      pinTimeoutFlag <= 1'b1;
    end
  end
`else
  assign timeoutCount   = '0;
  assign pinTimeoutFlag = 1'b0;
`endif

  // State and round-robin history register
  always_ff @(posedge pinClock or posedge pinReset) begin
    if (pinReset) begin
      state     <= IDLE;
      lastOwner <= 1'b1;
    end else begin
      state     <= nextState;
      lastOwner <= nextLastOwner;
    end
  end

  // Arbitration, grant release and RAM/master routing
  always_comb begin
    nextState            = state;
    nextLastOwner        = lastOwner;
    bus.pinWbCycleStrobe = 1'b0;
    bus.pinWbWriteEnable = 1'b0;
    bus.pinWbAddress     = 32'h0;
    bus.pinWbWriteData   = 32'h0;
    bus.pinM0Ack         = 1'b0;
    bus.pinM1Ack         = 1'b0;

    case (state)
      IDLE: begin
        if (bus.pinM0CycleStrobe && bus.pinM1CycleStrobe) begin
          nextState = lastOwner ? GRANT0 : GRANT1;
        end else if (bus.pinM0CycleStrobe) begin
          nextState = GRANT0;
        end else if (bus.pinM1CycleStrobe) begin
          nextState = GRANT1;
        end
      end

      GRANT0: begin
        bus.pinWbCycleStrobe = bus.pinM0CycleStrobe && !timeoutExpire;
        bus.pinWbWriteEnable = bus.pinM0WriteEnable;
        bus.pinWbAddress     = bus.pinM0Address;
        bus.pinWbWriteData   = bus.pinM0WriteData;
        bus.pinM0Ack         = bus.pinWbAck || timeoutExpire;
        if (bus.pinWbAck || !bus.pinM0CycleStrobe || timeoutExpire) begin
          nextState     = IDLE;
          nextLastOwner = 1'b0;
        end
      end

      GRANT1: begin
        bus.pinWbCycleStrobe = bus.pinM1CycleStrobe && !timeoutExpire;
        bus.pinWbWriteEnable = bus.pinM1WriteEnable;
        bus.pinWbAddress     = bus.pinM1Address;
        bus.pinWbWriteData   = bus.pinM1WriteData;
        bus.pinM1Ack         = bus.pinWbAck || timeoutExpire;
        if (bus.pinWbAck || !bus.pinM1CycleStrobe || timeoutExpire) begin
          nextState     = IDLE;
          nextLastOwner = 1'b1;
        end
      end

      default: begin
        nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter.
// Inputs change 2 time units after a rising edge, outputs are checked 1 unit
// later, well away from the next edge. Timeout checks need RAM_ARBITER_TIMEOUT_EN.
module tb_ram_arbiter;

  logic pinClock;
  logic pinReset;
  logic pinTimeoutFlag;
  int   checks;
  int   errors;

  ram_arbiter_if bus ();

  ram_arbiter #(.TIMEOUT_WIDTH(4)) dut (
    .pinClock       (pinClock),
    .pinReset       (pinReset),
    .bus            (bus),
    .pinTimeoutFlag (pinTimeoutFlag)
  );

  initial pinClock = 1'b0;
  always #5 pinClock = ~pinClock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkBus(input string tag, input logic cyc, input logic ack0,
                          input logic ack1);
    checkOutput({tag, ".cyc"},  {31'h0, bus.pinWbCycleStrobe}, {31'h0, cyc});
    checkOutput({tag, ".ack0"}, {31'h0, bus.pinM0Ack},         {31'h0, ack0});
    checkOutput({tag, ".ack1"}, {31'h0, bus.pinM1Ack},         {31'h0, ack1});
  endtask

  task automatic applyStimulus(input int m, input logic strobe, input logic we,
                               input logic [31:0] addr, input logic [31:0] data);
    if (m == 0) begin
      bus.pinM0CycleStrobe = strobe;
      bus.pinM0WriteEnable = we;
      bus.pinM0Address     = addr;
      bus.pinM0WriteData   = data;
    end else begin
      bus.pinM1CycleStrobe = strobe;
      bus.pinM1WriteEnable = we;
      bus.pinM1Address     = addr;
      bus.pinM1WriteData   = data;
    end
  endtask

  task automatic setRam(input logic ack, input logic [31:0] rdata);
    bus.pinWbAck      = ack;
    bus.pinWbReadData = rdata;
  endtask

  task automatic tick();
    @(posedge pinClock);
    #2;
  endtask

  task automatic resetDut();
    pinReset = 1'b1;
    #1;
    pinReset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pinReset = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    setRam(1'b0, 32'h0);
    #3;
    $display("[TB] reset state");
    checkBus("reset", 1'b0, 1'b0, 1'b0);
    checkOutput("reset.flag", {31'h0, pinTimeoutFlag}, 32'h0);
    checkOutput("reset.addr", bus.pinWbAddress, 32'h0);
    #1;
    pinReset = 1'b0;

    // Single M0 write, RAM acks in the third grant cycle
    $display("[TB] single M0 write");
    tick();
    applyStimulus(0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    #1;
    checkBus("w.arb", 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    checkBus("w.g1", 1'b1, 1'b0, 1'b0);
    checkOutput("w.we",    {31'h0, bus.pinWbWriteEnable}, 32'h1);
    checkOutput("w.addr",  bus.pinWbAddress,   32'h0000_0010);
    checkOutput("w.wdata", bus.pinWbWriteData, 32'hDEAD_BEEF);
    tick();
    #1;
    checkBus("w.g2", 1'b1, 1'b0, 1'b0);
    tick();
    setRam(1'b1, 32'hCAFE_0001);
    #1;
    checkBus("w.ack", 1'b1, 1'b1, 1'b0);
    checkOutput("w.rd0", bus.pinM0ReadData, 32'hCAFE_0001);
    checkOutput("w.rd1", bus.pinM1ReadData, 32'hCAFE_0001);
    tick();
    setRam(1'b0, 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkBus("w.idle", 1'b0, 1'b0, 1'b0);
    checkOutput("w.idleaddr", bus.pinWbAddress, 32'h0);

    // Simultaneous requests after reset: M0 first, M1 two cycles after M0 ack
    $display("[TB] tie after reset");
    resetDut();
    tick();
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    applyStimulus(1, 1'b1, 1'b1, 32'h0000_0200, 32'h1111_1111);
    #1;
    checkBus("tie.arb", 1'b0, 1'b0, 1'b0);
    tick();
    setRam(1'b1, 32'h0);
    #1;
    checkOutput("tie.addr0", bus.pinWbAddress, 32'h0000_0100);
    checkBus("tie.ack0", 1'b1, 1'b1, 1'b0);
    tick();
    setRam(1'b0, 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkBus("tie.gap", 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    checkBus("tie.g1", 1'b1, 1'b0, 1'b0);
    checkOutput("tie.addr1", bus.pinWbAddress,   32'h0000_0200);
    checkOutput("tie.we1",   {31'h0, bus.pinWbWriteEnable}, 32'h1);
    checkOutput("tie.wd1",   bus.pinWbWriteData, 32'h1111_1111);
    setRam(1'b1, 32'h0);
    #1;
    checkBus("tie.ack1", 1'b1, 1'b0, 1'b1);
    tick();
    setRam(1'b0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // M0 requests continuously, M1 once: M0, M1, M0
    $display("[TB] alternation");
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
    tick();
    #1;
    checkOutput("alt.first", bus.pinWbAddress, 32'h0000_0300);
    setRam(1'b1, 32'h0);
    tick();
    setRam(1'b0, 32'h0);
    #1;
    checkBus("alt.gap1", 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    checkOutput("alt.second", bus.pinWbAddress, 32'h0000_0400);
    setRam(1'b1, 32'h0);
    #1;
    checkBus("alt.ack1", 1'b1, 1'b0, 1'b1);
    tick();
    setRam(1'b0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    #1;
    checkBus("alt.third", 1'b1, 1'b0, 1'b0);
    checkOutput("alt.thirdaddr", bus.pinWbAddress, 32'h0000_0300);
    setRam(1'b1, 32'h0);
    tick();
    setRam(1'b0, 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Spurious RAM ack while idle
    $display("[TB] spurious ack");
    setRam(1'b1, 32'h0);
    #1;
    checkBus("spur.now", 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    checkBus("spur.next", 1'b0, 1'b0, 1'b0);
    setRam(1'b0, 32'h0);

    // Reset during GRANT1 (last owner was M0): tie afterwards goes to M0
    $display("[TB] reset mid-grant");
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
    tick();
    #1;
    checkBus("rst.g1", 1'b1, 1'b0, 1'b0);
    setRam(1'b1, 32'h0);
    pinReset = 1'b1;
    #1;
    checkBus("rst.drop", 1'b0, 1'b0, 1'b0);
    pinReset = 1'b0;
    setRam(1'b0, 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0600, 32'h0);
    tick();
    #1;
    checkBus("rst.tie", 1'b1, 1'b0, 1'b0);
    checkOutput("rst.tieaddr", bus.pinWbAddress, 32'h0000_0600);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkBus("rst.withdraw", 1'b0, 1'b0, 1'b0);
    tick();

`ifdef RAM_ARBITER_TIMEOUT_EN
    // RAM never acks: forced ack at grant cycle 15 (entry cycle is 0)
    $display("[TB] watchdog expiry");
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0700, 32'h0);
    tick();
    for (int i = 0; i < 14; i++) tick();
    #1;
    checkBus("to.c14", 1'b1, 1'b0, 1'b0);
    tick();
    #1;
    checkBus("to.c15", 1'b0, 1'b1, 1'b0);
    checkOutput("to.flagpre", {31'h0, pinTimeoutFlag}, 32'h0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("to.flag", {31'h0, pinTimeoutFlag}, 32'h1);
    checkBus("to.idle", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("to.sticky", {31'h0, pinTimeoutFlag}, 32'h1);
    resetDut();
    #1;
    checkOutput("to.cleared", {31'h0, pinTimeoutFlag}, 32'h0);

    // Real ack in the expiry cycle wins
    $display("[TB] ack at expiry");
    tick();
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0800, 32'h0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    setRam(1'b1, 32'h0);
    #1;
    checkBus("race.c15", 1'b1, 1'b1, 1'b0);
    tick();
    setRam(1'b0, 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("race.flag", {31'h0, pinTimeoutFlag}, 32'h0);
`else
    // Without the watchdog a grant waits indefinitely
    $display("[TB] no watchdog");
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0700, 32'h0);
    tick();
    for (int i = 0; i < 20; i++) tick();
    #1;
    checkBus("nto.hold", 1'b1, 1'b0, 1'b0);
    checkOutput("nto.flag", {31'h0, pinTimeoutFlag}, 32'h0);
    setRam(1'b1, 32'h0);
    #1;
    checkBus("nto.ack", 1'b1, 1'b1, 1'b0);
    tick();
    setRam(1'b0, 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_WIDTH, default 8: width of the grant watchdog counter.
REQ-002 SHALL have port pinClock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port pinReset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports pinM0CycleStrobe, pinM1CycleStrobe  input  1  per-master request; held high until that master's ack.
REQ-005 SHALL have ports pinM0WriteEnable, pinM1WriteEnable  input  1  per-master write flag.
REQ-006 SHALL have ports pinM0Address, pinM1Address  input  32  per-master address.
REQ-007 SHALL have ports pinM0WriteData, pinM1WriteData  input  32  per-master write data.
REQ-008 SHALL have ports pinM0ReadData, pinM1ReadData  output  32  read data returned to each master.
REQ-009 SHALL have ports pinM0Ack, pinM1Ack  output  1  per-master cycle-complete pulse.
REQ-010 SHALL have port pinWbCycleStrobe  output  1  RAM-side cycle request.
REQ-011 SHALL have port pinWbWriteEnable  output  1  RAM-side write flag.
REQ-012 SHALL have port pinWbAddress  output  32  RAM-side address.
REQ-013 SHALL have port pinWbWriteData  output  32  RAM-side write data.
REQ-014 SHALL have port pinWbReadData  input  32  RAM-side read data.
REQ-015 SHALL have port pinWbAck  input  1  RAM-side ack.
REQ-016 SHALL have port pinTimeoutFlag  output  1  sticky watchdog error.

Function
REQ-017 SHALL implement states IDLE, GRANT0, GRANT1.
REQ-018 IDLE: only M0 requesting -> GRANT0; only M1 requesting -> GRANT1; both requesting -> grant the master other than lastOwner; neither -> stay IDLE.
REQ-019 Grant SHALL be registered: a request visible in cycle N reaches the RAM side in cycle N+1 at the earliest.
REQ-020 In GRANTx, pinWb* outputs SHALL combinationally follow master x's strobe/enable/address/data.
REQ-021 In IDLE, pinWbCycleStrobe and pinWbWriteEnable SHALL be 0; address/data outputs 0.
REQ-022 pinMxAck SHALL equal pinWbAck only in GRANTx; the non-owner's ack SHALL be 0.
REQ-023 pinWbReadData SHALL drive both pinM0ReadData and pinM1ReadData unconditionally.
REQ-024 Cycle with pinWbAck=1 in GRANTx: next state IDLE, lastOwner <= x.
REQ-025 Owner dropping its strobe before ack: next state IDLE, lastOwner <= x; no ack issued.
REQ-026 pinWbAck while IDLE SHALL be ignored (no master ack, no state change).
REQ-027 Minimum spacing: after an ack, the next RAM-side strobe SHALL appear no earlier than 2 cycles later (ack cycle, then IDLE arbitration cycle).
REQ-028 A master re-requesting immediately after its ack SHALL lose to a waiting other master.

Reset
REQ-029 pinReset high SHALL immediately force state IDLE, lastOwner=1 (M0 wins first tie), watchdog counter 0, pinTimeoutFlag 0.
REQ-030 Reset mid-grant SHALL drop pinWbCycleStrobe and both acks to 0 asynchronously; an in-flight RAM cycle is abandoned.

Configuration
REQ-031 Macro RAM_ARBITER_TIMEOUT_EN defined: counter clears on entry to GRANTx, increments each GRANTx cycle without pinWbAck; on reaching 2^TIMEOUT_WIDTH-1 the arbiter SHALL, for one cycle, assert pinMxAck, force pinWbCycleStrobe to 0, set pinTimeoutFlag (sticky until reset), then go IDLE with lastOwner <= x.
REQ-032 Real pinWbAck in the same cycle as expiry SHALL win: normal ack, flag not set.
REQ-033 Macro undefined: no counter, pinTimeoutFlag tied 0, grants wait indefinitely.

Verification
REQ-034 Reset, M0 writes 0x0000_0010 data 0xDEADBEEF, RAM acks after 3 cycles -> RAM sees M0 fields from cycle 1, pinM0Ack one cycle, pinM1Ack 0.
REQ-035 Both request in same cycle after reset -> M0 served first, M1 strobe at RAM 2 cycles after M0 ack.
REQ-036 M0 requests continuously, M1 requests once -> strict alternation M0,M1,M0; M1 never starved.
REQ-037 Spurious pinWbAck in IDLE -> no master ack, state stays IDLE.
REQ-038 Reset asserted during GRANT1 -> pinWbCycleStrobe 0 same cycle, next tie goes to M0.
REQ-039 With RAM_ARBITER_TIMEOUT_EN, TIMEOUT_WIDTH=4, RAM never acks -> pinM0Ack pulse at grant cycle 15, pinTimeoutFlag=1 until reset; ack at cycle 15 instead -> flag stays 0.
